// File: rtl/spi_reg_frame_ctrl.sv
// SPI-slave frame controller: command byte, then a write/read data-byte stream with channel decode.
// Optional ADDR_AUTOINC_EN: advance the register address after every data byte of a burst.
module spi_reg_frame_ctrl #(
    parameter int ADDR_W            = 7,
    parameter int DATA_W            = 8,
    parameter int CH_REG_START_ADDR = 12,
    parameter int CH_REG_STOP_ADDR  = 67,
    parameter int REGS_PER_CH       = 7
) (
    input  logic              spi_clk,
    input  logic              rstn,
    input  logic              cs,
    input  logic              mosi,
    input  logic [DATA_W-1:0] rd_data,
    output logic              miso,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [2:0]        ch_idx,
    output logic [2:0]        ch_reg_sel,
    output logic              addr_wrap
);

    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    typedef enum logic {
        ST_CMD,
        ST_DATA
    } state_t;

    state_t            state, state_nxt;
    logic              full_rstn;
    logic [CNT_W-1:0]  bit_cnt;
    logic [DATA_W-2:0] sh_in;
    logic [DATA_W-1:0] sh_out;
    logic [DATA_W-1:0] byte_in;
    logic              rw_write;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] addr_adv;
    logic              addr_wraps;
    logic [ADDR_W-1:0] cmd_addr;
    logic              byte_done;
    logic              frame_first;
    logic              cmd_done;
    logic              do_write;
    logic              do_read_adv;

    // Dropping cs ends the frame exactly like a reset of the framing logic.
    assign full_rstn = rstn & cs;

    assign byte_in   = {sh_in, mosi};
    assign cmd_addr  = byte_in[ADDR_W-1:0];
    assign byte_done = (bit_cnt == LAST_BIT);

`ifdef ADDR_AUTOINC_EN
    assign addr_adv   = addr + ADDR_W'(1);
    assign addr_wraps = &addr;
`else
    assign addr_adv   = addr;
    assign addr_wraps = 1'b0;
`endif

    // Channel decode; the range test guards the subtraction against underflow.
    function automatic logic [5:0] decode(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] off;
        off = a - ADDR_W'(CH_REG_START_ADDR);
        if ((a >= ADDR_W'(CH_REG_START_ADDR)) && (a <= ADDR_W'(CH_REG_STOP_ADDR)))
            return {3'(off / ADDR_W'(REGS_PER_CH)), 3'(off % ADDR_W'(REGS_PER_CH))};
        else
            return {3'd0, 3'd7};
    endfunction

    always_ff @(posedge spi_clk or negedge full_rstn) begin
        if (!full_rstn)
            state <= ST_CMD;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        miso        = 1'b0;
        frame_first = 1'b0;
        cmd_done    = 1'b0;
        do_write    = 1'b0;
        do_read_adv = 1'b0;
        case (state)
            ST_CMD: begin
                frame_first = (bit_cnt == '0);
                cmd_done    = byte_done;
                if (byte_done)
                    state_nxt = ST_DATA;
            end
            ST_DATA: begin
                if (rw_write) begin
                    do_write = byte_done;
                end else begin
                    do_read_adv = byte_done;
                    miso = (bit_cnt == '0) ? rd_data[DATA_W-1] : sh_out[DATA_W-1];
                end
            end
            default: state_nxt = ST_CMD;
        endcase
    end

    // Bit counting, shifting and the write strobe are all discarded when cs drops.
    always_ff @(posedge spi_clk or negedge full_rstn) begin
        if (!full_rstn) begin
            bit_cnt  <= '0;
            sh_in    <= '0;
            sh_out   <= '0;
            rw_write <= 1'b0;
            wr_en    <= 1'b0;
        end else begin
            bit_cnt <= byte_done ? '0 : bit_cnt + CNT_W'(1);
            sh_in   <= byte_in[DATA_W-2:0];
            wr_en   <= do_write;
            if (cmd_done)
                rw_write <= byte_in[DATA_W-1];
            if (state == ST_DATA && !rw_write) begin
                if (bit_cnt == '0)
                    sh_out <= {rd_data[DATA_W-2:0], 1'b0};
                else
                    sh_out <= {sh_out[DATA_W-2:0], 1'b0};
            end
        end
    end

    // Address and register-bank outputs survive cs=0 so the last access stays visible.
    always_ff @(posedge spi_clk or negedge rstn) begin
        if (!rstn) begin
            addr       <= '0;
            wr_addr    <= '0;
            wr_data    <= '0;
            rd_addr    <= '0;
            ch_idx     <= 3'd0;
            ch_reg_sel <= 3'd7;
            addr_wrap  <= 1'b0;
        end else if (cs) begin
            if (frame_first)
                addr_wrap <= 1'b0;
            if (cmd_done) begin
                addr                 <= cmd_addr;
                rd_addr              <= cmd_addr;
                {ch_idx, ch_reg_sel} <= decode(cmd_addr);
            end
            if (do_write) begin
                wr_data              <= byte_in;
                wr_addr              <= addr;
                {ch_idx, ch_reg_sel} <= decode(addr);
                addr                 <= addr_adv;
                if (addr_wraps)
                    addr_wrap <= 1'b1;
            end
            if (do_read_adv) begin
                addr                 <= addr_adv;
                rd_addr              <= addr_adv;
                {ch_idx, ch_reg_sel} <= decode(addr_adv);
                if (addr_wraps)
                    addr_wrap <= 1'b1;
            end
        end
    end

endmodule
